wb_ctrl: RTL and testbench
==========================

# wb_ctrl

Writeback controller that drives the register-file write port (`a3`/`wd`/`we`) from two result producers: the single-cycle ALU and the variable-latency load unit. ALU results are written directly. Load results are buffered in a small FIFO and drained into write-port slots the ALU leaves idle. Writes to x0 are discarded. The block also reports per-source-register pending-write hazards to issue logic, with optional forwarding data.

## Interface
- `REG_W`, 5, register index width
- `DATA_W`, 32, data width
- `DEPTH`, 4, load FIFO entries; power of two, ≥2

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `alu_vld`  in  1  ALU result valid; always accepted, no ready
- `alu_rd`  in  REG_W  ALU destination register
- `alu_wd`  in  DATA_W  ALU result
- `ld_vld`  in  1  load result valid
- `ld_rdy`  out  1  load channel ready
- `ld_rd`  in  REG_W  load destination register
- `ld_wd`  in  DATA_W  load data
- `flush`  in  1  discard all queued loads
- `rf_a3`  out  REG_W  write address to register file
- `rf_wd`  out  DATA_W  write data to register file
- `rf_we`  out  1  write enable to register file
- `q1`, `q2`  in  REG_W  source registers queried by issue
- `hz1`, `hz2`  out  1  pending write to `q1`/`q2`
- `fwd1_vld`, `fwd2_vld`  out  1  forwarding value available (see Configuration)
- `fwd1_data`, `fwd2_data`  out  DATA_W  forwarded value
- `cnt`  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- **Load accept:** a load transfers when `ld_vld && ld_rdy`. `ld_rdy = (cnt != DEPTH)`, derived from registered state only, with no same-cycle pop credit.
- **x0 handling:** a transferred load with `ld_rd == 0` is consumed but not enqueued. An ALU result with `alu_rd == 0` is ignored.
- **Slot arbitration, each cycle:**
  - ALU has priority if `alu_vld && alu_rd != 0`; output stage loads the ALU result.
  - Otherwise, if the FIFO is non-empty, the head is popped into the output stage.
  - Otherwise `rf_we` is 0 next cycle.
- **Output stage:** `rf_a3`/`rf_wd`/`rf_we` are registers. `rf_a3`/`rf_wd` hold their last value when `rf_we` is 0.
- **Push and pop together:** allowed in the same cycle. `cnt` is unchanged and ordering is preserved.
- **Pointers:** wrap modulo DEPTH. `cnt` tracks full versus empty.
- **Flush:** on the next edge, pointers and `cnt` are cleared. A push in the same cycle is dropped and no pop occurs. The output stage is not cancelled; an already-registered write still commits. An ALU write in the flush cycle proceeds normally.
- **Hazards:** `hzN = (qN != 0) && (any valid FIFO entry rd == qN || (rf_we && rf_a3 == qN))`. Combinational from `qN` and registered state.
- **Ordering rule:** ordering between the ALU and load channels is the issuer's responsibility. Issue must not send an ALU result to an rd while `hz` shows it pending from a load.

## Timing
- **Reset (`rst_n` low):**
  - `cnt`=0, `rf_we`=0, `rf_a3`=0, `rf_wd`=0, FIFO empty.
  - Consequently `ld_rdy`=1, `hz*`=0, `fwd*`=0.
  - Inputs during reset are ignored.
  - Reset mid-operation loses all queued and in-flight writes.
- **Latency:**
  - ALU `alu_vld` in cycle N gives `rf_we`=1 in N+1; the register file is written at the end of N+1.
  - A load accepted in N into an empty FIFO with no ALU competition gives `rf_we` in N+2.
- **Throughput:** one register-file write per cycle. The FIFO drains only in ALU-idle cycles, so continuous ALU traffic starves loads. This is accepted; upstream must bound it.
- **Full:** with `cnt == DEPTH`, `ld_rdy`=0 for the whole cycle, even if a pop occurs.

## Configuration
- **`WB_FWD_EN` defined:**
  - `fwdN_vld` equals `hzN`.
  - `fwdN_data` is the youngest matching FIFO entry; if no FIFO entry matches, it is the output-stage data.
- **`WB_FWD_EN` undefined:** `fwdN_vld`=0 and `fwdN_data`=0. The ports remain present. Hazard logic is unchanged.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-traffic with 3 loads queued, then release. Expect `cnt`=0, `rf_we`=0, `rf_a3`=0, `ld_rdy`=1, and no stale write afterwards.
- **ALU priority:** ALU writes x5=0x11 every cycle while loads x6=0xA, x7=0xB are pushed. Expect only x5 writes while the ALU is active; when it idles, x6 then x7 on consecutive cycles.
- **Full/wrap:** push 4 loads x1..x4 with ALU busy. Expect `cnt`=4 and `ld_rdy`=0. Idle the ALU, then push 6 more while draining. Expect FIFO order x1..x10 preserved across pointer wrap.
- **x0 discard:** ALU rd=0 and load rd=0 with data 0xDEAD. Expect no `rf_we`, `cnt` unchanged, and the load handshake completes.
- **Flush:** 3 queued loads; assert `flush` while the head is in the output stage. Expect that write to commit, `cnt`=0 next cycle, and no further load writes.
- **Hazard/forward:** queue x9=0x1 then x9=0x2; set `q1`=9, `q2`=0. Expect `hz1`=1 and `hz2`=0. With `WB_FWD_EN` defined, `fwd1_data`=0x2; without it, `fwd1_vld`=0.

Source files
------------

// File: rtl/wb_ctrl_if.sv
// Bundle of writeback controller channels: ALU and load producers, register-file write port,
// issue-side hazard/forward queries and FIFO occupancy.
interface wb_ctrl_if #(
   parameter int unsigned REG_W  = 5,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 4
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic              alu_vld;
   logic [REG_W-1:0]  alu_rd;
   logic [DATA_W-1:0] alu_wd;
   logic              ld_vld;
   logic              ld_rdy;
   logic [REG_W-1:0]  ld_rd;
   logic [DATA_W-1:0] ld_wd;
   logic              flush;
   logic [REG_W-1:0]  rf_a3;
   logic [DATA_W-1:0] rf_wd;
   logic              rf_we;
   logic [REG_W-1:0]  q1;
   logic [REG_W-1:0]  q2;
   logic              hz1;
   logic              hz2;
   logic              fwd1_vld;
   logic              fwd2_vld;
   logic [DATA_W-1:0] fwd1_data;
   logic [DATA_W-1:0] fwd2_data;
   logic [CNT_W-1:0]  cnt;

   modport master (
      output alu_vld, alu_rd, alu_wd, ld_vld, ld_rd, ld_wd, flush, q1, q2,
      input  ld_rdy, rf_a3, rf_wd, rf_we, hz1, hz2, fwd1_vld, fwd2_vld, fwd1_data, fwd2_data,
             cnt
   );

   modport slave (
      input  alu_vld, alu_rd, alu_wd, ld_vld, ld_rd, ld_wd, flush, q1, q2,
      output ld_rdy, rf_a3, rf_wd, rf_we, hz1, hz2, fwd1_vld, fwd2_vld, fwd1_data, fwd2_data,
             cnt
   );
endinterface

// File: rtl/wb_ctrl.sv
// Writeback controller: ALU results win the register-file write port, loads queue in a FIFO
// and drain in ALU-idle cycles. Define WB_FWD_EN to enable hazard forwarding data.
module wb_ctrl #(
   parameter int unsigned REG_W  = 5,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 4
) (
   input logic      clk,
   input logic      rst_n,
   wb_ctrl_if.slave bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [REG_W-1:0]  fifo_rd_q [DEPTH];
   logic [DATA_W-1:0] fifo_wd_q [DEPTH];
   logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [REG_W-1:0]  rf_a3_q, rf_a3_d;
   logic [DATA_W-1:0] rf_wd_q, rf_wd_d;
   logic              rf_we_q, rf_we_d;
   logic              ld_rdy, alu_win, push, pop;

   // Ready depends only on registered occupancy: no credit for a same-cycle pop.
   assign ld_rdy = (cnt_q != CNT_W'(DEPTH));

   always_comb begin
      alu_win = bus.alu_vld && (bus.alu_rd != '0);
      push    = bus.ld_vld && ld_rdy && (bus.ld_rd != '0) && !bus.flush;
      pop     = !alu_win && (cnt_q != '0) && !bus.flush;
   end

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (bus.flush) begin
         wptr_d = '0;
         rptr_d = '0;
         cnt_d  = '0;
      end else begin
         if (push) wptr_d = wptr_q + PTR_W'(1);
         if (pop)  rptr_d = rptr_q + PTR_W'(1);
         if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
         else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_comb begin
      rf_a3_d = rf_a3_q;
      rf_wd_d = rf_wd_q;
      rf_we_d = 1'b0;
      if (alu_win) begin
         rf_a3_d = bus.alu_rd;
         rf_wd_d = bus.alu_wd;
         rf_we_d = 1'b1;
      end else if (pop) begin
         rf_a3_d = fifo_rd_q[rptr_q];
         rf_wd_d = fifo_wd_q[rptr_q];
         rf_we_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         rf_a3_q <= '0;
         rf_wd_q <= '0;
         rf_we_q <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
         rf_a3_q <= rf_a3_d;
         rf_wd_q <= rf_wd_d;
         rf_we_q <= rf_we_d;
      end
   end

   // Storage needs no reset: occupancy alone decides which entries are meaningful.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rd_q[wptr_q] <= bus.ld_rd;
         fifo_wd_q[wptr_q] <= bus.ld_wd;
      end
   end

   logic [REG_W-1:0] qry [2];
   logic [1:0]       hz;
   logic [PTR_W-1:0] idx;
`ifdef WB_FWD_EN
   logic [DATA_W-1:0] fdata [2];
`endif

   // Entries are scanned oldest to youngest so the last match is the youngest.
   always_comb begin
      qry[0] = bus.q1;
      qry[1] = bus.q2;
      hz     = '0;
      idx    = '0;
`ifdef WB_FWD_EN
      fdata[0] = rf_wd_q;
      fdata[1] = rf_wd_q;
`endif
      for (int j = 0; j < 2; j++) begin
         for (int k = 0; k < DEPTH; k++) begin
            idx = rptr_q + PTR_W'(k);
            if ((CNT_W'(k) < cnt_q) && (fifo_rd_q[idx] == qry[j])) begin
               hz[j] = 1'b1;
`ifdef WB_FWD_EN
               fdata[j] = fifo_wd_q[idx];
`endif
            end
         end
         if (rf_we_q && (rf_a3_q == qry[j])) hz[j] = 1'b1;
         if (qry[j] == '0) hz[j] = 1'b0;
      end
   end

   assign bus.ld_rdy = ld_rdy;
   assign bus.rf_a3  = rf_a3_q;
   assign bus.rf_wd  = rf_wd_q;
   assign bus.rf_we  = rf_we_q;
   assign bus.cnt    = cnt_q;
   assign bus.hz1    = hz[0];
   assign bus.hz2    = hz[1];
`ifdef WB_FWD_EN
   assign bus.fwd1_vld  = hz[0];
   assign bus.fwd2_vld  = hz[1];
   assign bus.fwd1_data = fdata[0];
   assign bus.fwd2_data = fdata[1];
`else
   assign bus.fwd1_vld  = 1'b0;
   assign bus.fwd2_vld  = 1'b0;
   assign bus.fwd1_data = '0;
   assign bus.fwd2_data = '0;
`endif
endmodule

// File: tb/tb_wb_ctrl.sv
// Self-checking bench for wb_ctrl: a vector table driven against a queue-based reference model,
// with expected register-file writes scoreboarded, plus a hand-written mid-traffic reset.
module tb_wb_ctrl;
   localparam int unsigned DEPTH = 4;

   typedef struct packed {
      logic        alu_vld;
      logic [4:0]  alu_rd;
      logic [31:0] alu_wd;
      logic        ld_vld;
      logic [4:0]  ld_rd;
      logic [31:0] ld_wd;
      logic        flush;
      logic [4:0]  q1;
      logic [4:0]  q2;
   } vec_t;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] wd;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   wb_ctrl_if #(.REG_W(5), .DATA_W(32), .DEPTH(DEPTH)) bus ();
   wb_ctrl #(.REG_W(5), .DATA_W(32), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          n_vec = 0;
   int          n_err = 0;
   ent_t        mq [$];
   ent_t        exp_q [$];
   logic        m_we;
   logic [4:0]  m_a3;
   logic [31:0] m_wd;
   vec_t        vecs [$];

   function automatic vec_t mkv(input logic av, input logic [4:0] ard, input logic [31:0] awd,
                                input logic lv, input logic [4:0] lrd, input logic [31:0] lwd,
                                input logic fl, input logic [4:0] q1, input logic [4:0] q2);
      vec_t v;
      v = '{av, ard, awd, lv, lrd, lwd, fl, q1, q2};
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      exp_q.delete();
      m_we = 1'b0;
      m_a3 = '0;
      m_wd = '0;
   endtask

   task automatic model_step(input vec_t v, output bit acc);
      bit   rdy;
      ent_t e;
      rdy = (mq.size() != DEPTH);
      acc = v.ld_vld && rdy;
      if (v.alu_vld && v.alu_rd != 0) begin
         m_we = 1'b1; m_a3 = v.alu_rd; m_wd = v.alu_wd;
      end else if (!v.flush && mq.size() != 0) begin
         e = mq.pop_front();
         m_we = 1'b1; m_a3 = e.rd; m_wd = e.wd;
      end else begin
         m_we = 1'b0;
      end
      if (m_we) exp_q.push_back('{m_a3, m_wd});
      if (v.flush) mq.delete();
      else if (acc && v.ld_rd != 0) mq.push_back('{v.ld_rd, v.ld_wd});
   endtask

   task automatic model_hz(input logic [4:0] q, output logic hz, output logic [31:0] d);
      hz = 1'b0;
      d  = m_wd;
      if (q != 0) begin
         foreach (mq[i]) if (mq[i].rd == q) begin
            hz = 1'b1;
            d  = mq[i].wd;
         end
         if (m_we && m_a3 == q) hz = 1'b1;
      end
   endtask

   task automatic check_all();
      ent_t        e;
      logic        hz;
      logic [31:0] d;
      chk("cnt", 32'(bus.cnt), 32'(mq.size()));
      chk("ld_rdy", 32'(bus.ld_rdy), 32'(mq.size() != DEPTH));
      chk("rf_we", 32'(bus.rf_we), 32'(m_we));
      if (m_we) begin
         if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            chk("rf_a3", 32'(bus.rf_a3), 32'(e.rd));
            chk("rf_wd", bus.rf_wd, e.wd);
         end
      end else begin
         chk("rf_a3_hold", 32'(bus.rf_a3), 32'(m_a3));
         chk("rf_wd_hold", bus.rf_wd, m_wd);
      end
      model_hz(bus.q1, hz, d);
      chk("hz1", 32'(bus.hz1), 32'(hz));
`ifdef WB_FWD_EN
      chk("fwd1_vld", 32'(bus.fwd1_vld), 32'(hz));
      if (hz) chk("fwd1_data", bus.fwd1_data, d);
`else
      chk("fwd1_vld", 32'(bus.fwd1_vld), 32'd0);
      chk("fwd1_data", bus.fwd1_data, 32'd0);
`endif
      model_hz(bus.q2, hz, d);
      chk("hz2", 32'(bus.hz2), 32'(hz));
`ifdef WB_FWD_EN
      chk("fwd2_vld", 32'(bus.fwd2_vld), 32'(hz));
      if (hz) chk("fwd2_data", bus.fwd2_data, d);
`else
      chk("fwd2_vld", 32'(bus.fwd2_vld), 32'd0);
      chk("fwd2_data", bus.fwd2_data, 32'd0);
`endif
   endtask

   task automatic drive(input vec_t v);
      bus.alu_vld = v.alu_vld; bus.alu_rd = v.alu_rd; bus.alu_wd = v.alu_wd;
      bus.ld_vld  = v.ld_vld;  bus.ld_rd  = v.ld_rd;  bus.ld_wd  = v.ld_wd;
      bus.flush   = v.flush;   bus.q1     = v.q1;     bus.q2     = v.q2;
   endtask

   // Called at a negedge: drive, predict, let the edge happen, then compare at the next negedge.
   task automatic step(input vec_t v, output bit acc);
      drive(v);
      model_step(v, acc);
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   initial begin
      bit   acc;
      int   tries;
      vec_t idle;
      idle = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // ALU priority: x5 keeps the port while x6/x7 queue, then they drain in order.
      vecs.push_back(mkv(1, 5, 32'h11, 1, 6, 32'hA, 0, 6, 5));
      vecs.push_back(mkv(1, 5, 32'h11, 1, 7, 32'hB, 0, 7, 0));
      vecs.push_back(mkv(1, 5, 32'h11, 0, 0, 0, 0, 6, 7));
      for (int i = 0; i < 3; i++) vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 6, 7));
      // Full and wrap: fill under ALU traffic, then stream six more while draining.
      for (int i = 1; i <= 4; i++) vecs.push_back(mkv(1, 5, 32'h11, 1, 5'(i), 32'h100 + i, 0, 0, 0));
      vecs.push_back(mkv(1, 5, 32'h11, 0, 0, 0, 0, 3, 4));
      for (int i = 5; i <= 10; i++) vecs.push_back(mkv(0, 0, 0, 1, 5'(i), 32'h100 + i, 0, 5'(i), 1));
      for (int i = 0; i < 6; i++) vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 10, 9));
      // x0 discard on both channels.
      vecs.push_back(mkv(1, 0, 32'h55, 1, 0, 32'hDEAD, 0, 0, 0));
      vecs.push_back(idle);
      vecs.push_back(idle);
      // Flush with the head in the output stage and a push in the flush cycle.
      for (int i = 11; i <= 13; i++) vecs.push_back(mkv(1, 5, 32'h11, 1, 5'(i), 32'h200 + i, 0, 12, 13));
      vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 11, 12));
      vecs.push_back(mkv(0, 0, 0, 1, 14, 32'h214, 1, 11, 14));
      for (int i = 0; i < 3; i++) vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 12, 14));
      // Hazard/forward: two loads to x9, youngest value should be forwarded.
      vecs.push_back(mkv(1, 5, 32'h11, 1, 9, 32'h1, 0, 9, 0));
      vecs.push_back(mkv(1, 5, 32'h11, 1, 9, 32'h2, 0, 9, 0));
      vecs.push_back(mkv(1, 5, 32'h11, 0, 0, 0, 0, 9, 0));
      for (int i = 0; i < 4; i++) vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 9, 0));

      drive(idle);
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      rst_n = 1'b1;
      @(negedge clk);
      check_all();

      foreach (vecs[n]) begin
         tries = 0;
         do begin
            step(vecs[n], acc);
            tries++;
         end while (vecs[n].ld_vld && !acc && tries < 8);
         if (vecs[n].ld_vld && !acc) chk("ld_accept_timeout", 32'(acc), 32'd1);
      end

      // Reset mid-traffic with three loads queued behind the ALU.
      for (int i = 20; i <= 22; i++) step(mkv(1, 5, 32'h11, 1, 5'(i), 32'h300 + i, 0, 20, 21), acc);
      drive(mkv(1, 5, 32'h11, 1, 23, 32'h323, 0, 20, 21));
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      check_all();
      drive(mkv(0, 0, 0, 0, 0, 0, 0, 20, 22));
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) step(mkv(0, 0, 0, 0, 0, 0, 0, 20, 22), acc);

      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
